// File: rtl/picomips_core_if.sv
// Bus bundle for picomips_core: instruction ROM port, switch input handshake
// and LED output. The core binds the master modport, the board/ROM side the slave.
interface picomips_core_if #(
  parameter int DW    = 8,
  parameter int NREG  = 8,
  parameter int PSIZE = 5
);
  localparam int RA    = $clog2(NREG);
  localparam int ISIZE = 3 + 2*RA + DW;

  logic [PSIZE-1:0] iaddr;
  logic [ISIZE-1:0] idata;

  // Input handshake: a word transfers on an enabled clk edge where
  // in_valid & in_ready are both high; in_valid is a level strobe that the
  // core requires to drop before it will take another word.
  logic [DW-1:0]    in_data;
  logic             in_valid;
  logic             in_ready;

  logic [DW-1:0]    dataout;
  logic             out_valid;

  modport master (
    output iaddr,
    input  idata,
    input  in_data,
    input  in_valid,
    output in_ready,
    output dataout,
    output out_valid
  );

  modport slave (
    input  iaddr,
    output idata,
    output in_data,
    output in_valid,
    input  in_ready,
    input  dataout,
    input  out_valid
  );
endinterface

// File: rtl/picomips_core.sv
// Single-issue picoMIPS core: PC, register file, fractional multiply ALU,
// branches and a one-word-per-strobe input FSM. PICOMIPS_SAT_EN selects saturating arithmetic.
module picomips_core #(
  parameter int DW    = 8,
  parameter int NREG  = 8,
  parameter int PSIZE = 5,
  parameter int FRAC  = DW - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  picomips_core_if.master   bus,
  output logic              dbg_in_state
);
  localparam int RA    = $clog2(NREG);
  localparam int ISIZE = 3 + 2*RA + DW;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADD  = 3'b001,
    OP_ADDI = 3'b010,
    OP_MULI = 3'b011,
    OP_IN   = 3'b100,
    OP_OUT  = 3'b101,
    OP_BEQ  = 3'b110,
    OP_J    = 3'b111
  } opcode_e;

  typedef enum logic {
    IN_ARMED    = 1'b0,
    IN_DISARMED = 1'b1
  } in_state_e;

  logic [PSIZE-1:0] pc_q, pc_d;
  logic [DW-1:0]    regs_q [NREG];
  logic [DW-1:0]    regs_d [NREG];
  logic [DW-1:0]    dataout_q, dataout_d;
  logic             out_valid_q, out_valid_d;
  in_state_e        state_q, state_d;

  opcode_e          op;
  logic [RA-1:0]    rd;
  logic [RA-1:0]    rs;
  logic [DW-1:0]    imm;
  logic [DW-1:0]    rd_val;
  logic [DW-1:0]    rs_val;

  logic signed [2*DW-1:0] mul_prod;
  logic [DW-1:0]    add_res;
  logic [DW-1:0]    addi_res;
  logic [DW-1:0]    mul_res;

  logic             wr_en;
  logic [DW-1:0]    wr_data;
  logic             in_ready;

  assign op  = opcode_e'(bus.idata[ISIZE-1 -: 3]);
  assign rd  = bus.idata[DW+2*RA-1 -: RA];
  assign rs  = bus.idata[DW+RA-1 -: RA];
  assign imm = bus.idata[DW-1:0];

  assign rd_val = (rd == '0) ? '0 : regs_q[rd];
  assign rs_val = (rs == '0) ? '0 : regs_q[rs];

  assign mul_prod = $signed({{DW{rs_val[DW-1]}}, rs_val}) *
                    $signed({{DW{imm[DW-1]}}, imm});

`ifdef PICOMIPS_SAT_EN
  localparam logic signed [2*DW-1:0] SAT_MAX = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW-1:0] SAT_MIN = {{(DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] sat(input logic signed [2*DW-1:0] v);
    if (v > SAT_MAX)      sat = SAT_MAX[DW-1:0];
    else if (v < SAT_MIN) sat = SAT_MIN[DW-1:0];
    else                  sat = v[DW-1:0];
  endfunction

  // Operands widened to 2*DW so the true result is known before clamping.
  assign add_res  = sat($signed({{DW{rd_val[DW-1]}}, rd_val}) +
                        $signed({{DW{rs_val[DW-1]}}, rs_val}));
  assign addi_res = sat($signed({{DW{rd_val[DW-1]}}, rd_val}) +
                        $signed({{DW{imm[DW-1]}}, imm}));
  assign mul_res  = sat(mul_prod >>> FRAC);
`else
  assign add_res  = rd_val + rs_val;
  assign addi_res = rd_val + imm;
  assign mul_res  = DW'(mul_prod >>> FRAC);
`endif

  always_comb begin
    pc_d        = pc_q;
    state_d     = state_q;
    dataout_d   = dataout_q;
    out_valid_d = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    in_ready    = 1'b0;

    if (en) begin
      pc_d     = pc_q + 1'b1;
      in_ready = !rst && (state_q == IN_ARMED) && (op == OP_IN);

      // Re-arm on any enabled clk with the strobe low, whatever is executing.
      if (state_q == IN_DISARMED && !bus.in_valid) state_d = IN_ARMED;

      case (op)
        OP_ADD:  begin wr_en = 1'b1; wr_data = add_res;  end
        OP_ADDI: begin wr_en = 1'b1; wr_data = addi_res; end
        OP_MULI: begin wr_en = 1'b1; wr_data = mul_res;  end
        OP_IN: begin
          if (state_q == IN_ARMED && bus.in_valid) begin
            wr_en   = 1'b1;
            wr_data = bus.in_data;
            state_d = IN_DISARMED;
          end else begin
            pc_d = pc_q;
          end
        end
        OP_OUT: begin
          dataout_d   = rs_val;
          out_valid_d = 1'b1;
        end
        OP_BEQ: if (rd_val == rs_val) pc_d = imm[PSIZE-1:0];
        OP_J:   pc_d = imm[PSIZE-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    if (wr_en && rd != '0) regs_d[rd] = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      dataout_q   <= '0;
      out_valid_q <= 1'b0;
      state_q     <= IN_ARMED;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      pc_q        <= pc_d;
      dataout_q   <= dataout_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign bus.iaddr     = pc_q;
  assign bus.dataout   = dataout_q;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready;
  assign dbg_in_state  = state_q;
endmodule

// File: tb/tb_picomips_core.sv
// Self-checking bench for picomips_core: directed programs in a bench-held ROM,
// OUT results checked against an expected queue by a negedge monitor.
module tb_picomips_core;
  localparam int DW    = 8;
  localparam int NREG  = 8;
  localparam int PSIZE = 5;
  localparam int ISIZE = 17;

  localparam logic [2:0] NOP = 3'd0, ADD = 3'd1, ADDI = 3'd2, MULI = 3'd3,
                         INS = 3'd4, OUT = 3'd5, BEQ = 3'd6, JMP = 3'd7;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic dbg_in_state;

  logic [ISIZE-1:0] rom [32];
  logic [DW-1:0]    exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  picomips_core_if #(.DW(DW), .NREG(NREG), .PSIZE(PSIZE)) bus ();

  assign bus.idata = rom[bus.iaddr];

  picomips_core #(.DW(DW), .NREG(NREG), .PSIZE(PSIZE), .FRAC(DW-1)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .bus          (bus),
    .dbg_in_state (dbg_in_state)
  );

  function automatic logic [ISIZE-1:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                           input logic [2:0] rs, input logic [7:0] imm);
    enc = {op, rd, rs, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = '0;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_program();
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;
  endtask

  // Monitor: every out_valid cycle consumes one expected dataout value.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got dataout=%0h, required no output", bus.dataout);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.dataout !== e) begin
          errors++;
          $display("FAIL out_data: got %0h, required %0h", bus.dataout, e);
        end
      end
    end
  end

  logic [PSIZE-1:0] trace2 [16];

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    clear_rom();
    #12;
    check("reset_iaddr", bus.iaddr, 0);
    check("reset_dataout", bus.dataout, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_fsm", dbg_in_state, 0);

    // All-NOP ROM: PC counts and wraps.
    start_program();
    for (int k = 1; k <= 33; k++) begin
      edge_step();
      check("nop_iaddr", bus.iaddr, k % 32);
    end
    check("nop_dataout", bus.dataout, 0);

    // Arithmetic, r0, branches and jump.
    rst = 1'b1;
    en  = 1'b0;
    clear_rom();
    rom[0]  = enc(ADDI, 3'd1, 3'd0, 8'd100);
    rom[1]  = enc(MULI, 3'd2, 3'd1, 8'h40);
    rom[2]  = enc(OUT,  3'd0, 3'd2, 8'd0);
    rom[3]  = enc(ADDI, 3'd4, 3'd0, 8'h80);
    rom[4]  = enc(MULI, 3'd5, 3'd4, 8'h80);
    rom[5]  = enc(OUT,  3'd0, 3'd5, 8'd0);
    rom[6]  = enc(ADD,  3'd6, 3'd1, 8'd0);
    rom[7]  = enc(ADD,  3'd6, 3'd1, 8'd0);
    rom[8]  = enc(OUT,  3'd0, 3'd6, 8'd0);
    rom[9]  = enc(ADDI, 3'd0, 3'd0, 8'd5);
    rom[10] = enc(OUT,  3'd0, 3'd0, 8'd0);
    rom[11] = enc(BEQ,  3'd1, 3'd6, 8'd20);
    rom[12] = enc(ADDI, 3'd7, 3'd0, 8'd100);
    rom[13] = enc(BEQ,  3'd1, 3'd7, 8'd17);
    rom[14] = enc(OUT,  3'd0, 3'd1, 8'd0);
    rom[17] = enc(JMP,  3'd0, 3'd0, 8'h1F);
    exp_q.push_back(8'd50);
`ifdef PICOMIPS_SAT_EN
    exp_q.push_back(8'h7F);
    exp_q.push_back(8'h7F);
`else
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hC8);
`endif
    exp_q.push_back(8'h00);
    trace2 = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
               5'd11, 5'd12, 5'd13, 5'd17, 5'd31, 5'd0};
    start_program();
    for (int k = 0; k < 16; k++) begin
      edge_step();
      check("prog_iaddr", bus.iaddr, trace2[k]);
    end
    en = 1'b0;
    repeat (3) edge_step();
    check("en_low_frozen_pc", bus.iaddr, 0);
    check("en_low_out_valid", bus.out_valid, 0);

    // Input handshake: stall, one word per strobe, en=0 and reset mid-stall.
    rst = 1'b1;
    clear_rom();
    rom[0] = enc(INS, 3'd3, 3'd0, 8'd0);
    rom[1] = enc(INS, 3'd4, 3'd0, 8'd0);
    rom[2] = enc(OUT, 3'd0, 3'd3, 8'd0);
    rom[3] = enc(OUT, 3'd0, 3'd4, 8'd0);
    rom[4] = enc(INS, 3'd5, 3'd0, 8'd0);
    rom[5] = enc(JMP, 3'd0, 3'd0, 8'd5);
    exp_q.push_back(8'h2A);
    exp_q.push_back(8'h55);
    start_program();
    for (int k = 0; k < 5; k++) begin
      edge_step();
      check("in_stall_iaddr", bus.iaddr, 0);
      check("in_stall_ready", bus.in_ready, 1);
    end
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h2A;
    for (int k = 0; k < 10; k++) begin
      edge_step();
      check("in_long_strobe_iaddr", bus.iaddr, 1);
      check("in_long_strobe_ready", bus.in_ready, 0);
      check("in_long_strobe_fsm", dbg_in_state, 1);
    end
    bus.in_valid = 1'b0;
    edge_step();
    check("in_rearm_iaddr", bus.iaddr, 1);
    check("in_rearm_ready", bus.in_ready, 1);
    check("in_rearm_fsm", dbg_in_state, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h55;
    edge_step();
    check("in_second_iaddr", bus.iaddr, 2);
    bus.in_valid = 1'b0;
    repeat (2) edge_step();
    check("in_third_iaddr", bus.iaddr, 4);
    check("in_third_ready", bus.in_ready, 1);
    en = 1'b0;
    #1;
    check("en_low_in_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    repeat (3) edge_step();
    check("en_low_in_iaddr", bus.iaddr, 4);
    check("en_low_in_fsm", dbg_in_state, 0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_en_low_iaddr", bus.iaddr, 0);
    check("rst_en_low_out_valid", bus.out_valid, 0);
    check("rst_en_low_fsm", dbg_in_state, 0);

    // Reset while stalled with en=1.
    bus.in_valid = 1'b0;
    clear_rom();
    rom[0] = enc(ADDI, 3'd3, 3'd0, 8'd9);
    rom[1] = enc(INS,  3'd3, 3'd0, 8'd0);
    rom[2] = enc(OUT,  3'd0, 3'd3, 8'd0);
    rom[3] = enc(JMP,  3'd0, 3'd0, 8'd3);
    start_program();
    repeat (3) edge_step();
    check("stall_before_rst_iaddr", bus.iaddr, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_stall_iaddr", bus.iaddr, 0);
    check("rst_stall_ready", bus.in_ready, 0);
    check("rst_stall_fsm", dbg_in_state, 0);
    check("rst_stall_out_valid", bus.out_valid, 0);

    // Registers cleared by reset; BEQ r0,r0 behaves as a jump.
    clear_rom();
    rom[0] = enc(OUT,  3'd0, 3'd3, 8'd0);
    rom[1] = enc(OUT,  3'd0, 3'd4, 8'd0);
    rom[2] = enc(ADDI, 3'd1, 3'd0, 8'd3);
    rom[3] = enc(OUT,  3'd0, 3'd1, 8'd0);
    rom[4] = enc(BEQ,  3'd0, 3'd0, 8'd4);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h03);
    start_program();
    repeat (6) edge_step();
    check("beq_r0_iaddr", bus.iaddr, 4);
    check("final_dataout", bus.dataout, 3);

    @(negedge clk);
    #1;
    check("exp_q_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
